// File: rtl/calc_pkg.sv
// Shared types and constants for the remainder-unit scheduler.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    localparam int unsigned OPW  = 3;
    localparam int unsigned RESW = 5;

    localparam logic REQ_ENTRY    = 1'b0;
    localparam logic REQ_SELFTEST = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant pointer moves only on an accepted grant.
module rr_arbiter2
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant_valid,
    output logic       grant
);

    logic last_q;

    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant = ~last_q;
        end else if (req[REQ_SELFTEST]) begin
            grant = REQ_SELFTEST;
        end else begin
            grant = REQ_ENTRY;
        end
    end

    // Reset pointer at the self-test requester so operand entry wins first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_SELFTEST;
        end else if (accept) begin
            last_q <= grant;
        end
    end

endmodule

// File: rtl/rem_unit_scheduler.sv
// Shares one combinational remainder unit between the operand-entry and self-test requesters.
module rem_unit_scheduler
    import calc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned DBZ_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*OPW-1:0]     req_num,
    input  logic [2*OPW-1:0]     req_den,
    output logic [1:0]           resp_valid,
    input  logic [1:0]           resp_ready,
    output logic [RESW-1:0]      resp_rem,
    output logic                 resp_dbz,
    output logic                 resp_zero,
    output logic [OPW-1:0]       unit_num,
    output logic [OPW-1:0]       unit_den,
    input  logic [RESW-1:0]      unit_rem,
    input  logic                 unit_dbz,
    input  logic                 unit_zero,
    output logic                 busy,
    output logic [DBZ_CNT_W-1:0] dbz_count
);

    localparam int unsigned CntW = 4;

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [OPW-1:0]       num_q, num_d, den_q, den_d;
    logic [RESW-1:0]      rem_q, rem_d;
    logic                 dbz_q, dbz_d, zero_q, zero_d;
    logic [DBZ_CNT_W-1:0] dbz_cnt_q, dbz_cnt_d;
    logic                 grant, grant_valid, accept;

    // req_ready is raised for the grant whenever any request is pending, so accept needs no ANDing.
    assign accept = (state_q == IDLE) && grant_valid;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_valid),
        .accept      (accept),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        den_d      = den_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        zero_d     = zero_q;
        dbz_cnt_d  = dbz_cnt_q;
        req_ready  = 2'b00;
        resp_valid = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    req_ready[grant] = 1'b1;
                    owner_d          = grant;
                    cnt_d            = CntW'(SETTLE_CYCLES - 1);
                    state_d          = ISSUE;
                    if (grant == REQ_SELFTEST) begin
                        num_d = req_num[2*OPW-1:OPW];
                        den_d = req_den[2*OPW-1:OPW];
                    end else begin
                        num_d = req_num[OPW-1:0];
                        den_d = req_den[OPW-1:0];
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == '0) begin
                    rem_d   = unit_rem;
                    dbz_d   = unit_dbz;
                    zero_d  = unit_zero;
                    state_d = RESP;
                    if (unit_dbz && (dbz_cnt_q != '1)) begin
                        dbz_cnt_d = dbz_cnt_q + DBZ_CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            RESP: begin
                resp_valid[owner_q] = 1'b1;
                if (resp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= REQ_ENTRY;
            cnt_q     <= '0;
            num_q     <= '0;
            den_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
            zero_q    <= 1'b0;
            dbz_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            den_q     <= den_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
            zero_q    <= zero_d;
            dbz_cnt_q <= dbz_cnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign unit_num  = num_q;
    assign unit_den  = den_q;
    assign resp_rem  = rem_q;
    assign resp_dbz  = dbz_q;
    assign resp_zero = zero_q;
    assign dbz_count = dbz_cnt_q;

endmodule

// File: tb/tb_rem_unit_scheduler.sv
// Scoreboard bench for rem_unit_scheduler with a behavioural remainder unit beside each instance.
module tb_rem_unit_scheduler;
    import calc_pkg::*;

    localparam int unsigned SETTLE  = 1;
    localparam int unsigned SETTLE2 = 4;
    localparam int unsigned DW      = 8;

    typedef struct packed {
        logic       owner;
        logic [4:0] rem;
        logic       dbz;
        logic       zero;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, rst_n2;
    logic [1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [5:0]    req_num, req_den;
    logic [4:0]    resp_rem, unit_rem;
    logic          resp_dbz, resp_zero, unit_dbz, unit_zero, busy;
    logic [2:0]    unit_num, unit_den;
    logic [DW-1:0] dbz_count;

    logic [1:0]    req_valid2, req_ready2, resp_valid2, resp_ready2;
    logic [5:0]    req_num2, req_den2;
    logic [4:0]    resp_rem2, unit_rem2;
    logic          resp_dbz2, resp_zero2, unit_dbz2, unit_zero2, busy2;
    logic [2:0]    unit_num2, unit_den2;
    logic [DW-1:0] dbz_count2;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          exp_dbz_cnt = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Signed-magnitude remainder: sign follows the numerator, zero results are positive.
    function automatic logic [6:0] unit_model(input logic [2:0] n, input logic [2:0] d);
        logic [1:0] m;
        if (d[1:0] == 2'b00) return {5'b00000, 1'b1, 1'b1};
        m = n[1:0] % d[1:0];
        return {(m != 2'b00) & n[2], 2'b00, m, 1'b0, m == 2'b00};
    endfunction

    assign {unit_rem, unit_dbz, unit_zero}    = unit_model(unit_num, unit_den);
    assign {unit_rem2, unit_dbz2, unit_zero2} = unit_model(unit_num2, unit_den2);

    rem_unit_scheduler #(.SETTLE_CYCLES(SETTLE), .DBZ_CNT_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_num(req_num), .req_den(req_den), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rem(resp_rem), .resp_dbz(resp_dbz), .resp_zero(resp_zero),
        .unit_num(unit_num), .unit_den(unit_den), .unit_rem(unit_rem), .unit_dbz(unit_dbz),
        .unit_zero(unit_zero), .busy(busy), .dbz_count(dbz_count)
    );

    rem_unit_scheduler #(.SETTLE_CYCLES(SETTLE2), .DBZ_CNT_W(DW)) dut2 (
        .clk(clk), .rst_n(rst_n2), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_num(req_num2), .req_den(req_den2), .resp_valid(resp_valid2),
        .resp_ready(resp_ready2), .resp_rem(resp_rem2), .resp_dbz(resp_dbz2),
        .resp_zero(resp_zero2), .unit_num(unit_num2), .unit_den(unit_den2),
        .unit_rem(unit_rem2), .unit_dbz(unit_dbz2), .unit_zero(unit_zero2), .busy(busy2),
        .dbz_count(dbz_count2)
    );

    task automatic push_exp(input logic owner, input logic [4:0] rem, input logic dbz,
                            input logic zero);
        exp_t e;
        e.owner = owner;
        e.rem   = rem;
        e.dbz   = dbz;
        e.zero  = zero;
        sb.push_back(e);
        if (dbz && exp_dbz_cnt < (1 << DW) - 1) exp_dbz_cnt++;
    endtask

    task automatic run_txn(input logic owner, input logic [2:0] num, input logic [2:0] den,
                           input logic [4:0] erem, input logic edbz, input logic ezero,
                           input string name);
        int unsigned t_acc;
        int          n;
        exp_t        e;
        logic [1:0]  obit;
        obit = owner ? 2'b10 : 2'b01;
        @(negedge clk);
        req_valid = obit;
        if (owner) begin
            req_num[5:3] = num;
            req_den[5:3] = den;
        end else begin
            req_num[2:0] = num;
            req_den[2:0] = den;
        end
        #1;
        n = 0;
        while ((req_ready & obit) == 2'b00 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if ((req_ready & obit) == 2'b00) begin
            errors++;
            $display("FAIL %s accept: req_ready=%b required=%b", name, req_ready, obit);
            req_valid = 2'b00;
            return;
        end
        t_acc = cyc + 1;
        push_exp(owner, erem, edbz, ezero);
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_issue: busy=%b required=1", name, busy);
        end
        n = 0;
        while (resp_valid == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        checks++;
        if (resp_valid !== obit) begin
            errors++;
            $display("FAIL %s resp_valid: got=%b required=%b", name, resp_valid, obit);
            return;
        end
        checks++;
        if (cyc != t_acc + SETTLE) begin
            errors++;
            $display("FAIL %s latency: got=%0d required=%0d", name, cyc - t_acc, SETTLE);
        end
        checks++;
        if ({resp_rem, resp_dbz, resp_zero} !== {e.rem, e.dbz, e.zero}) begin
            errors++;
            $display("FAIL %s result: rem/dbz/zero=%b/%b/%b required=%b/%b/%b", name,
                     resp_rem, resp_dbz, resp_zero, e.rem, e.dbz, e.zero);
        end
        resp_ready = obit;
        @(negedge clk);
        resp_ready = 2'b00;
        checks++;
        if (resp_valid !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s complete: resp_valid=%b busy=%b required=00/0", name, resp_valid,
                     busy);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        rst_n2 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_rem, resp_dbz, resp_zero, unit_num, unit_den, busy,
             dbz_count} !== '0) begin
            errors++;
            $display("FAIL reset_dut: rdy=%b vld=%b rem=%b num=%b den=%b busy=%b cnt=%0d req=0",
                     req_ready, resp_valid, resp_rem, unit_num, unit_den, busy, dbz_count);
        end
        checks++;
        if ({req_ready2, resp_valid2, resp_rem2, resp_dbz2, resp_zero2, unit_num2, unit_den2,
             busy2, dbz_count2} !== '0) begin
            errors++;
            $display("FAIL reset_dut2: rdy=%b vld=%b busy=%b required all zero", req_ready2,
                     resp_valid2, busy2);
        end
        rst_n  = 1'b1;
        rst_n2 = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: busy=%b resp_valid=%b required 0/00", busy, resp_valid);
        end
    endtask

    task automatic test_entry();
        run_txn(REQ_ENTRY, 3'b011, 3'b010, 5'b00001, 1'b0, 1'b0, "entry");
    endtask

    task automatic test_selftest();
        run_txn(REQ_SELFTEST, 3'b111, 3'b010, 5'b10001, 1'b0, 1'b0, "selftest");
    endtask

    task automatic test_back_to_back();
        int          acc_n;
        int          resp_n;
        int unsigned acc_cyc[4];
        logic        acc_own[4];
        exp_t        e;
        @(negedge clk);
        req_num    = {3'b011, 3'b101};
        req_den    = {3'b110, 3'b011};
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        acc_n  = 0;
        resp_n = 0;
        for (int i = 0; i < 40 && resp_n < 4; i++) begin
            #1;
            if ((req_valid & req_ready) != 2'b00 && acc_n < 4) begin
                acc_own[acc_n] = req_ready[1];
                acc_cyc[acc_n] = cyc + 1;
                if (req_ready[1]) push_exp(1'b1, 5'b00001, 1'b0, 1'b0);
                else push_exp(1'b0, 5'b10001, 1'b0, 1'b0);
                acc_n++;
            end
            if (resp_valid != 2'b00) begin
                e = sb.pop_front();
                resp_n++;
                checks++;
                if (resp_valid !== (e.owner ? 2'b10 : 2'b01) ||
                    {resp_rem, resp_dbz, resp_zero} !== {e.rem, e.dbz, e.zero}) begin
                    errors++;
                    $display("FAIL b2b resp%0d: vld=%b rem=%b required owner=%0d rem=%b",
                             resp_n, resp_valid, resp_rem, e.owner, e.rem);
                end
            end
            @(negedge clk);
            if (acc_n == 4) req_valid = 2'b00;
        end
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        checks++;
        if (acc_n != 4 || resp_n != 4) begin
            errors++;
            $display("FAIL b2b count: accepts=%0d responses=%0d required 4/4", acc_n, resp_n);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (acc_own[k] !== k[0]) begin
                    errors++;
                    $display("FAIL b2b order%0d: grant=%0d required=%0d", k, acc_own[k], k[0]);
                end
                if (k > 0) begin
                    checks++;
                    if (acc_cyc[k] - acc_cyc[k-1] != SETTLE + 2) begin
                        errors++;
                        $display("FAIL b2b spacing%0d: got=%0d required=%0d", k,
                                 acc_cyc[k] - acc_cyc[k-1], SETTLE + 2);
                    end
                end
            end
        end
    endtask

    task automatic test_dbz();
        logic [2:0] den;
        logic [6:0] m;
        run_txn(REQ_ENTRY, 3'b010, 3'b000, 5'b00000, 1'b1, 1'b1, "dbz");
        checks++;
        if (dbz_count !== 8'd1) begin
            errors++;
            $display("FAIL dbz_count1: got=%0d required=1", dbz_count);
        end
        for (int i = 1; i < 300; i++) begin
            den = i[0] ? 3'b100 : 3'b000;
            m = unit_model(3'b010, den);
            run_txn(REQ_ENTRY, 3'b010, den, m[6:2], m[1], m[0], "dbz_sat");
        end
        checks++;
        if (dbz_count !== 8'd255 || int'(dbz_count) != exp_dbz_cnt) begin
            errors++;
            $display("FAIL dbz_saturate: got=%0d required=255", dbz_count);
        end
    endtask

    task automatic test_stall();
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid    = 2'b10;
        req_num[5:3] = 3'b110;
        req_den[5:3] = 3'b011;
        #1;
        n = 0;
        while (req_ready != 2'b10 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        push_exp(1'b1, 5'b10010, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = 2'b00;
        n = 0;
        while (resp_valid == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        for (int i = 0; i < 14; i++) begin
            if (i == 10) resp_ready = 2'b01;
            checks++;
            if (resp_valid !== 2'b10 ||
                {resp_rem, resp_dbz, resp_zero} !== {e.rem, e.dbz, e.zero}) begin
                errors++;
                $display("FAIL stall%0d: vld=%b rem=%b dbz=%b zero=%b required 10/%b/%b/%b",
                         i, resp_valid, resp_rem, resp_dbz, resp_zero, e.rem, e.dbz, e.zero);
            end
            @(negedge clk);
        end
        resp_ready = 2'b10;
        @(negedge clk);
        resp_ready = 2'b00;
        checks++;
        if (resp_valid !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_complete: vld=%b busy=%b required 00/0", resp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned t_acc;
        int          n;
        // First a full divide-by-zero transaction so the counter and pointer are non-reset.
        @(negedge clk);
        req_num2   = {3'b000, 3'b011};
        req_den2   = {3'b000, 3'b000};
        req_valid2 = 2'b01;
        #1;
        t_acc = cyc + 1;
        @(negedge clk);
        req_valid2 = 2'b00;
        n = 0;
        while (resp_valid2 == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (resp_valid2 !== 2'b01 || cyc != t_acc + SETTLE2 ||
            {resp_rem2, resp_dbz2, resp_zero2} !== 7'b0000011) begin
            errors++;
            $display("FAIL s4_txn: vld=%b lat=%0d rem=%b dbz=%b zero=%b required 01/4/0/1/1",
                     resp_valid2, cyc - t_acc, resp_rem2, resp_dbz2, resp_zero2);
        end
        resp_ready2 = 2'b01;
        @(negedge clk);
        resp_ready2 = 2'b00;
        checks++;
        if (dbz_count2 !== 8'd1) begin
            errors++;
            $display("FAIL s4_dbz_count: got=%0d required=1", dbz_count2);
        end
        req_den2   = {3'b000, 3'b010};
        req_valid2 = 2'b01;
        @(negedge clk);
        req_valid2 = 2'b00;
        @(negedge clk);
        checks++;
        if (busy2 !== 1'b1 || unit_num2 !== 3'b011 || unit_den2 !== 3'b010) begin
            errors++;
            $display("FAIL s4_issue: busy=%b num=%b den=%b required 1/011/010", busy2,
                     unit_num2, unit_den2);
        end
        rst_n2 = 1'b0;
        #1;
        checks++;
        if ({req_ready2, resp_valid2, resp_rem2, resp_dbz2, resp_zero2, unit_num2, unit_den2,
             busy2, dbz_count2} !== '0) begin
            errors++;
            $display("FAIL s4_async_reset: vld=%b num=%b den=%b busy=%b cnt=%0d required 0",
                     resp_valid2, unit_num2, unit_den2, busy2, dbz_count2);
        end
        @(negedge clk);
        rst_n2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid2 !== 2'b00 || busy2 !== 1'b0) begin
                errors++;
                $display("FAIL s4_abort%0d: vld=%b busy=%b required 00/0", i, resp_valid2,
                         busy2);
            end
        end
        req_valid2 = 2'b11;
        #1;
        checks++;
        if (req_ready2 !== 2'b01) begin
            errors++;
            $display("FAIL s4_contention: req_ready=%b required=01", req_ready2);
        end
        req_valid2 = 2'b00;
    endtask

    initial begin
        req_valid   = 2'b00;
        resp_ready  = 2'b00;
        req_num     = '0;
        req_den     = '0;
        req_valid2  = 2'b00;
        resp_ready2 = 2'b00;
        req_num2    = '0;
        req_den2    = '0;
        test_reset();
        test_entry();
        test_selftest();
        test_back_to_back();
        test_dbz();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
